// File: rtl/regfile_write_decode.sv
// 32-entry register file: one-hot write decode into per-register enables,
// two independent 2:1 mux-tree read ports, register 0 hardwired to zero.
module regfile_write_decode #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr1,
   input  logic [ADDR_BITS-1:0] rd_addr2,
   output logic [WIDTH-1:0]     rd_data1,
   output logic [WIDTH-1:0]     rd_data2,
   output logic                 wr_ack
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic             wr_accept;
   logic [DEPTH-1:0] wr_sel;
   logic [WIDTH-1:0] mem   [1:DEPTH-1];
   logic [WIDTH-1:0] tree1 [1:2*DEPTH-1];
   logic [WIDTH-1:0] tree2 [1:2*DEPTH-1];

   assign wr_accept = wr_en && (wr_addr != '0);

   always_comb begin
      wr_sel = '0;
      if (wr_accept) begin
         wr_sel[wr_addr] = 1'b1;
      end
   end

   // Entry 0 has no storage; its enable is never raised.
   for (genvar i = 1; i < DEPTH; i++) begin : g_reg
      always_ff @(posedge clk) begin
         if (reset) begin
            mem[i] <= '0;
         end else if (wr_sel[i]) begin
            mem[i] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ack <= 1'b0;
      end else begin
         wr_ack <= wr_accept;
      end
   end

   // Heap-ordered trees: node k has children 2k/2k+1, leaves at DEPTH+index.
   // Level l (root = 0) is steered by address bit ADDR_BITS-1-l.
   assign tree1[DEPTH] = '0;
   assign tree2[DEPTH] = '0;
   for (genvar i = 1; i < DEPTH; i++) begin : g_leaf
      assign tree1[DEPTH+i] = mem[i];
      assign tree2[DEPTH+i] = mem[i];
   end

   for (genvar l = 0; l < ADDR_BITS; l++) begin : g_lvl
      for (genvar j = 0; j < 2 ** l; j++) begin : g_node
         localparam int K = (2 ** l) + j;
         assign tree1[K] = rd_addr1[ADDR_BITS-1-l] ? tree1[2*K+1] : tree1[2*K];
         assign tree2[K] = rd_addr2[ADDR_BITS-1-l] ? tree2[2*K+1] : tree2[2*K];
      end
   end

   assign rd_data1 = tree1[1];
   assign rd_data2 = tree2[1];

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed bench for regfile_write_decode: reset, write decode, r0 discard,
// back-to-back writes, hold, reset-over-write.
module tb_regfile_write_decode;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic        wr_ack;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model [32];

   regfile_write_decode #(.WIDTH(32), .ADDR_BITS(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr_ack   (wr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_pair(input string tag, input int a, input int b);
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(b);
      #1;
      check($sformatf("%s rd1 r%0d", tag, a), rd_data1, model[a]);
      check($sformatf("%s rd2 r%0d", tag, b), rd_data2, model[b]);
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // 1: reset, then sweep both ports
      @(negedge clk);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s1 wr_ack", {31'b0, wr_ack}, 32'h0);
      for (int i = 0; i < 32; i++) read_pair("s1", i, 31 - i);

      // 2: write r5; old value before the edge, new after, ack one cycle
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFB08E248;
      rd_addr1 = 5'd5; rd_addr2 = 5'd5;
      #1;
      check("s2 pre-edge rd1", rd_data1, 32'h0);
      check("s2 pre-edge rd2", rd_data2, 32'h0);
      tick();
      wr_en = 1'b0;
      model[5] = 32'hFB08E248;
      #1;
      check("s2 rd1", rd_data1, 32'hFB08E248);
      check("s2 rd2", rd_data2, 32'hFB08E248);
      check("s2 wr_ack", {31'b0, wr_ack}, 32'h1);
      tick();
      check("s2 wr_ack drop", {31'b0, wr_ack}, 32'h0);

      // 3: write to r0 is discarded
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
      tick();
      wr_en = 1'b0;
      check("s3 wr_ack", {31'b0, wr_ack}, 32'h0);
      for (int i = 0; i < 32; i++) read_pair("s3", i, 31 - i);

      // 4: back-to-back writes to r1..r31
      for (int i = 1; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = i * 32'h01010101;
         tick();
         model[i] = i * 32'h01010101;
         check($sformatf("s4 wr_ack %0d", i), {31'b0, wr_ack}, 32'h1);
      end
      wr_en = 1'b0;
      tick();
      check("s4 wr_ack end", {31'b0, wr_ack}, 32'h0);
      for (int i = 0; i < 32; i++) read_pair("s4", i, 31 - i);

      // same address on consecutive edges: last wins
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA0001;
      tick();
      wr_data = 32'hBBBB0002;
      tick();
      wr_en = 1'b0;
      model[3] = 32'hBBBB0002;
      read_pair("last-wins", 3, 4);
      check("last-wins wr_ack", {31'b0, wr_ack}, 32'h1);

      // 5: wr_en=0 leaves r7 alone
      wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'h12345678;
      tick();
      tick();
      check("s5 wr_ack", {31'b0, wr_ack}, 32'h0);
      read_pair("s5", 7, 0);

      // 6: reset wins over a simultaneous write
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h94C68187;
      reset = 1'b1;
      tick();
      reset = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      check("s6 wr_ack", {31'b0, wr_ack}, 32'h0);
      read_pair("s6 r9", 9, 9);
      for (int i = 0; i < 32; i++) read_pair("s6", i, 31 - i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
